// File: rtl/dmem_resp.sv
// Multi-cycle data-memory responder: accepts one request at a time, completes it after
// a fixed latency with a one-cycle done pulse, and flags misaligned or out-of-range accesses.
module dmem_resp #(
    parameter int LATENCY = 3,
    parameter int AW      = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        wr,
    input  logic [15:0] addr,
    input  logic [15:0] data_in,
    output logic [15:0] data_out,
    output logic        stall,
    output logic        done,
    output logic        err
);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    localparam int          DEPTH    = 1 << AW;
    localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 2);

    state_t          state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [AW-1:0]   idx_q, idx_d;
    logic [15:0]     wdata_q, wdata_d;
    logic            wr_q, wr_d;
    logic            bad_q, bad_d;
    logic            err_q, err_d;
    logic [15:0]     data_out_q, data_out_d;
    logic [15:0]     mem_q [DEPTH];
    logic [15:0]     mem_d [DEPTH];

    logic            accept;
    logic            req_bad;

    assign accept  = enable && (state_q != BUSY);
    // Bits above the word index must be zero; the shift keeps this legal for any AW.
    assign req_bad = addr[0] || ((addr >> (AW + 1)) != 16'd0);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        wdata_d    = wdata_q;
        wr_d       = wr_q;
        bad_d      = bad_q;
        err_d      = 1'b0;
        data_out_d = data_out_q;
        mem_d      = mem_q;

        case (state_q)
            BUSY: begin
                if (cnt_q == 4'd0) begin
                    state_d = DONE;
                    err_d   = bad_q;
                    if (!bad_q) begin
                        if (wr_q) begin
                            mem_d[idx_q] = wdata_q;
                        end else begin
                            data_out_d = mem_q[idx_q];
                        end
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Acceptance from DONE overrides the return to IDLE, giving zero-bubble chaining.
        if (accept) begin
            state_d = BUSY;
            cnt_d   = CNT_INIT;
            idx_d   = addr[AW:1];
            wdata_d = data_in;
            wr_d    = wr;
            bad_d   = req_bad;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            cnt_q      <= 4'd0;
            idx_q      <= '0;
            wdata_q    <= 16'h0000;
            wr_q       <= 1'b0;
            bad_q      <= 1'b0;
            err_q      <= 1'b0;
            data_out_q <= 16'h0000;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= 16'h0000;
            end
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            wdata_q    <= wdata_d;
            wr_q       <= wr_d;
            bad_q      <= bad_d;
            err_q      <= err_d;
            data_out_q <= data_out_d;
            mem_q      <= mem_d;
        end
    end

    assign stall    = (state_q == BUSY);
    assign done     = (state_q == DONE);
    assign err      = err_q;
    assign data_out = data_out_q;

endmodule

// File: tb/tb_dmem_resp.sv
// Scoreboard bench for dmem_resp: one LATENCY=3 instance for the main scenarios and
// one LATENCY=2 instance for the back-to-back cadence.
module tb_dmem_resp;

    typedef struct {
        int          cyc;
        logic        err;
        logic [15:0] data;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        en1, en2;
    logic        wr;
    logic [15:0] addr;
    logic [15:0] dataIn;
    logic [15:0] dataOut1, dataOut2;
    logic        stall1, stall2;
    logic        done1, done2;
    logic        err1, err2;

    int   cyc;
    int   nCompared;
    int   nMismatched;
    exp_t q1[$];
    exp_t q2[$];

    dmem_resp #(.LATENCY(3), .AW(8)) dut1 (
        .clk      (clk),
        .rst      (rst),
        .enable   (en1),
        .wr       (wr),
        .addr     (addr),
        .data_in  (dataIn),
        .data_out (dataOut1),
        .stall    (stall1),
        .done     (done1),
        .err      (err1)
    );

    dmem_resp #(.LATENCY(2), .AW(8)) dut2 (
        .clk      (clk),
        .rst      (rst),
        .enable   (en2),
        .wr       (wr),
        .addr     (addr),
        .data_in  (dataIn),
        .data_out (dataOut2),
        .stall    (stall2),
        .done     (done2),
        .err      (err2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
        nCompared++;
        if (act !== expv) begin
            nMismatched++;
            $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    task automatic idleCycle();
        @(posedge clk);
        #1;
    endtask

    // Drives one request in the current cycle, queues its expected completion, and walks
    // to its done cycle checking stall; hold keeps enable high (read of 0x0040) while stalled.
    task automatic applyStimulus(input int which, input logic w, input logic [15:0] a,
                                 input logic [15:0] d, input logic expErr,
                                 input logic [15:0] expData, input bit hold);
        int    lat;
        exp_t  e;
        string nm;
        lat  = (which == 1) ? 3 : 2;
        wr     = w;
        addr   = a;
        dataIn = d;
        if (which == 1) en1 = 1'b1;
        else            en2 = 1'b1;
        e.cyc  = cyc + lat;
        e.err  = expErr;
        e.data = expData;
        if (which == 1) q1.push_back(e);
        else            q2.push_back(e);
        for (int k = 1; k <= lat; k++) begin
            @(posedge clk);
            #1;
            if (k == 1) begin
                if (hold) begin
                    wr   = 1'b0;
                    addr = 16'h0040;
                end else begin
                    en1 = 1'b0;
                    en2 = 1'b0;
                end
            end
            if (k == lat) begin
                en1 = 1'b0;
                en2 = 1'b0;
            end
            if (k < lat) nm = $sformatf("dut%0d stall busy", which);
            else         nm = $sformatf("dut%0d stall in done", which);
            checkOutput(nm, (which == 1) ? {31'd0, stall1} : {31'd0, stall2}, (k < lat) ? 32'd1 : 32'd0);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            if (done1) begin
                if (q1.size() == 0) begin
                    nCompared++;
                    nMismatched++;
                    $display("[TB] FAIL dut1 unexpected done: got done=1 expected none (cycle %0d)", cyc);
                end else begin
                    e = q1.pop_front();
                    checkOutput("dut1 done cycle", cyc, e.cyc);
                    checkOutput("dut1 err", {31'd0, err1}, {31'd0, e.err});
                    checkOutput("dut1 data_out", {16'd0, dataOut1}, {16'd0, e.data});
                end
            end else begin
                checkOutput("dut1 err without done", {31'd0, err1}, 32'd0);
            end
            if (done2) begin
                if (q2.size() == 0) begin
                    nCompared++;
                    nMismatched++;
                    $display("[TB] FAIL dut2 unexpected done: got done=1 expected none (cycle %0d)", cyc);
                end else begin
                    e = q2.pop_front();
                    checkOutput("dut2 done cycle", cyc, e.cyc);
                    checkOutput("dut2 err", {31'd0, err2}, {31'd0, e.err});
                    checkOutput("dut2 data_out", {16'd0, dataOut2}, {16'd0, e.data});
                end
            end else begin
                checkOutput("dut2 err without done", {31'd0, err2}, 32'd0);
            end
        end
    end

    initial begin
        nCompared   = 0;
        nMismatched = 0;
        rst    = 1'b0;
        en1    = 1'b0;
        en2    = 1'b0;
        wr     = 1'b0;
        addr   = 16'h0000;
        dataIn = 16'h0000;

        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset stall", {31'd0, stall1}, 32'd0);
        checkOutput("reset done", {31'd0, done1}, 32'd0);
        checkOutput("reset err", {31'd0, err1}, 32'd0);
        checkOutput("reset data_out", {16'd0, dataOut1}, 32'd0);
        rst = 1'b1;

        // First request right after reset release, then write/read chained with no bubble.
        applyStimulus(1, 1'b0, 16'h0010, 16'h0000, 1'b0, 16'h0000, 1'b0);
        idleCycle();
        applyStimulus(1, 1'b1, 16'h0020, 16'hBEEF, 1'b0, 16'h0000, 1'b0);
        applyStimulus(1, 1'b0, 16'h0020, 16'h0000, 1'b0, 16'hBEEF, 1'b0);
        idleCycle();

        // Enable held through the stall must not start a second request.
        applyStimulus(1, 1'b1, 16'h0030, 16'h1111, 1'b0, 16'hBEEF, 1'b1);
        idleCycle();
        applyStimulus(1, 1'b0, 16'h0020, 16'h0000, 1'b0, 16'hBEEF, 1'b0);
        idleCycle();
        applyStimulus(1, 1'b0, 16'h0030, 16'h0000, 1'b0, 16'h1111, 1'b0);
        idleCycle();

        // Misaligned and out-of-range requests complete with err and leave memory alone.
        applyStimulus(1, 1'b1, 16'h0003, 16'h1234, 1'b1, 16'h1111, 1'b0);
        applyStimulus(1, 1'b1, 16'h8000, 16'h5678, 1'b1, 16'h1111, 1'b0);
        applyStimulus(1, 1'b0, 16'h0002, 16'h0000, 1'b0, 16'h0000, 1'b0);
        applyStimulus(1, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0);
        applyStimulus(1, 1'b0, 16'h0200, 16'h0000, 1'b1, 16'h0000, 1'b0);
        applyStimulus(1, 1'b1, 16'h01FE, 16'hCAFE, 1'b0, 16'h0000, 1'b0);
        applyStimulus(1, 1'b0, 16'h01FE, 16'h0000, 1'b0, 16'hCAFE, 1'b0);
        idleCycle();

        // Reset in the first busy cycle of a write: no done, nothing committed.
        wr     = 1'b1;
        addr   = 16'h0008;
        dataIn = 16'hAAAA;
        en1    = 1'b1;
        @(posedge clk);
        #1;
        en1 = 1'b0;
        rst = 1'b0;
        #1;
        checkOutput("mid-request reset stall", {31'd0, stall1}, 32'd0);
        checkOutput("mid-request reset data_out", {16'd0, dataOut1}, 32'd0);
        #1;
        rst = 1'b1;
        repeat (5) idleCycle();
        applyStimulus(1, 1'b0, 16'h0008, 16'h0000, 1'b0, 16'h0000, 1'b0);
        applyStimulus(1, 1'b0, 16'h0020, 16'h0000, 1'b0, 16'h0000, 1'b0);
        idleCycle();

        // LATENCY=2 instance: two writes then four reads, all back-to-back.
        applyStimulus(2, 1'b1, 16'h0002, 16'hA1A1, 1'b0, 16'h0000, 1'b0);
        applyStimulus(2, 1'b1, 16'h0004, 16'hB2B2, 1'b0, 16'h0000, 1'b0);
        applyStimulus(2, 1'b0, 16'h0002, 16'h0000, 1'b0, 16'hA1A1, 1'b0);
        applyStimulus(2, 1'b0, 16'h0004, 16'h0000, 1'b0, 16'hB2B2, 1'b0);
        applyStimulus(2, 1'b0, 16'h0006, 16'h0000, 1'b0, 16'h0000, 1'b0);
        applyStimulus(2, 1'b0, 16'h0002, 16'h0000, 1'b0, 16'hA1A1, 1'b0);

        repeat (6) idleCycle();
        checkOutput("dut1 pending responses", q1.size(), 32'd0);
        checkOutput("dut2 pending responses", q2.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule

// File: doc/dmem_resp.md
DMEM_RESP -- requirements
Module: dmem_resp

Interface
REQ-001 Parameter LATENCY, default 3, SHALL set cycles from request acceptance to done; legal range 2..15.
REQ-002 Parameter AW, default 8, SHALL set word-address width; the array holds 2^AW 16-bit words.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst  input  1  SHALL be the reset: asynchronous, active-low.
REQ-005 enable  input  1  SHALL be the request strobe from the memory stage.
REQ-006 wr  input  1  SHALL select the request type: 1 write, 0 read.
REQ-007 addr  input  16  SHALL be the byte address; the word index is addr[AW:1].
REQ-008 data_in  input  16  SHALL be the write data.
REQ-009 data_out  output  16  SHALL be the read data, valid in the done cycle.
REQ-010 stall  output  1  SHALL be high while a request is in flight and new requests are refused.
REQ-011 done  output  1  SHALL be a one-cycle completion pulse.
REQ-012 err  output  1  SHALL flag a failed request; valid only with done.

Function
REQ-013 FSM states SHALL be IDLE, BUSY and DONE, with a down-counter of width 4.
REQ-014 A request SHALL be accepted on a rising edge where enable=1 and state is IDLE or DONE; addr, data_in and wr are captured at that edge.
REQ-015 On acceptance the FSM SHALL enter BUSY with counter=LATENCY-2, then decrement each cycle, and go to DONE on the edge where counter=0.
REQ-016 done SHALL be 1 exactly LATENCY cycles after the acceptance cycle; with LATENCY=3, acceptance in cycle 0 gives stall=1 in cycles 1..2 and done=1 in cycle 3.
REQ-017 stall SHALL equal (state==BUSY); stall=0 in IDLE and DONE.
REQ-018 enable while stall=1 SHALL be ignored; no capture and no state change.
REQ-019 From DONE the FSM SHALL go to BUSY if a new request is present (back-to-back, zero bubble), otherwise to IDLE.
REQ-020 Read: data_out SHALL present mem[captured index] in the done cycle and hold that value until the next done.
REQ-021 Write: mem[captured index] SHALL update on the edge entering DONE; data_out SHALL be unchanged by writes.
REQ-022 A read accepted in the DONE cycle of a write to the same word SHALL return the newly written data.
REQ-023 Error cases:
  - addr[0]=1 (misaligned), or
  - any of addr[15:AW+1] nonzero (out of range).
  In either case the request SHALL complete with the normal latency and err=1 in the done cycle, with no array write and data_out held.
REQ-024 err SHALL be 0 whenever done=0.
REQ-025 wr and addr SHALL be don't-care when enable=0.

Reset
REQ-026 rst=0 SHALL asynchronously force:
  - state=IDLE, counter=0;
  - stall=0, done=0, err=0, data_out=16'h0000;
  - all array words=16'h0000.
REQ-027 Reset asserted mid-request SHALL abandon the request; no write is committed and no done pulse is produced after release.
REQ-028 The first request SHALL be accepted on the first rising edge after rst returns high with enable=1.

Verification
REQ-029 Reset then read addr=16'h0010 (LATENCY=3) -> stall=1 in cycles 1-2; done=1, err=0, data_out=16'h0000 in cycle 3.
REQ-030 Write addr=16'h0020 data=16'hBEEF, then read addr=16'h0020 issued in the write's done cycle -> read done 3 cycles later with data_out=16'hBEEF, no idle cycle between the two requests.
REQ-031 Write at cycle 0, then enable=1 with addr=16'h0040 held during cycles 1-2 (stall=1) and dropped in cycle 3 -> exactly one done; mem[0x20] unchanged.
REQ-032 Write 16'h1234 to addr=16'h0003 and 16'h5678 to addr=16'h8000 -> both report done=1 with err=1; later reads of 16'h0002 and 16'h0000 return 16'h0000.
REQ-033 rst=0 pulsed in cycle 1 of a write of 16'hAAAA to 16'h0008 -> no done pulse; a later read of 16'h0008 returns 16'h0000.
REQ-034 LATENCY=2, four back-to-back reads -> done pulses every 2 cycles, stall=1 only in the cycle after each acceptance.
